// File: rtl/univ_count_shift.sv
`default_nettype none
// ----------------------------------------------------------------------------
// univ_count_shift : N-bit universal register (load/shift/rotate/count), rev 1.0
// ----------------------------------------------------------------------------
module univ_count_shift #(
  parameter int     N       = 8,
  parameter longint MODULUS = 256,
  parameter bit     SAT     = 1'b0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         En,
  input  logic [2:0]   Mode,
  input  logic [N-1:0] D,
  input  logic         SerIn,
  output logic [N-1:0] Q,
  output logic         SerOut,
  output logic         Tc,
  output logic         Ovf
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_SHL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_UP   = 3'b110;
  localparam logic [2:0] MODE_DOWN = 3'b111;

  // Terminal value held at N+1 bits so MODULUS = 2^N stays representable.
  localparam logic [N:0] LIMIT = (N+1)'(MODULUS - 1);
  localparam logic [N:0] ONE   = (N+1)'(1);

  logic [N:0]   q_ext;
  logic [N:0]   q_inc;
  logic [N:0]   q_dec;
  logic [N-1:0] q_next;
  logic         ser_next;
  logic         ovf_next;

  assign q_ext = {1'b0, Q};
  assign q_inc = q_ext + ONE;
  assign q_dec = q_ext - ONE;

  assign Tc = ((Mode == MODE_UP) && (q_ext >= LIMIT)) ||
              ((Mode == MODE_DOWN) && (q_ext == '0));

  always_comb begin
    q_next   = Q;
    ser_next = SerOut;
    ovf_next = 1'b0;
    case (Mode)
      MODE_HOLD: q_next = Q;
      MODE_LOAD: q_next = D;
      MODE_SHR: begin
        q_next   = {SerIn, Q[N-1:1]};
        ser_next = Q[0];
      end
      MODE_SHL: begin
        q_next   = {Q[N-2:0], SerIn};
        ser_next = Q[N-1];
      end
      MODE_ROR: begin
        q_next   = {Q[0], Q[N-1:1]};
        ser_next = Q[0];
      end
      MODE_ROL: begin
        q_next   = {Q[N-2:0], Q[N-1]};
        ser_next = Q[N-1];
      end
      MODE_UP: begin
        if (q_ext < LIMIT) begin
          q_next = q_inc[N-1:0];
        end else begin
          q_next   = SAT ? LIMIT[N-1:0] : '0;
          ovf_next = 1'b1;
        end
      end
      MODE_DOWN: begin
        // An out-of-range value is clamped to the limit without flagging Ovf.
        if (q_ext == '0) begin
          q_next   = SAT ? '0 : LIMIT[N-1:0];
          ovf_next = 1'b1;
        end else if (q_ext > LIMIT) begin
          q_next = LIMIT[N-1:0];
        end else begin
          q_next = q_dec[N-1:0];
        end
      end
      default: q_next = Q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Q      <= '0;
      SerOut <= 1'b0;
      Ovf    <= 1'b0;
    end else if (!En) begin
      Ovf    <= 1'b0;
    end else begin
      Q      <= q_next;
      SerOut <= ser_next;
      Ovf    <= ovf_next;
    end
  end

endmodule
`default_nettype wire
